key_request_conditioner: RTL and testbench

- Input-conditioning stage directly upstream of the traffic controller FSM.
- Takes the raw active-low KEY push buttons (southbound left, NS walk, EW walk) and does three things per key: synchronises, debounces, and latches the request. Each latched request is held until the FSM acknowledges service.
- Replaces the plain combinational inversion of the KEY inputs. The FSM's request inputs then become clean, sticky levels that cannot be lost between FSM polls.
- Runs on the divided clk produced by the clock block.

---
 rtl/key_request_if.sv | 28 ++
 rtl/key_request_conditioner.sv | 110 +++++++++++
 tb/tb_key_request_conditioner.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/key_request_if.sv
// Bundle of the per-key request signals between the button conditioner and its neighbours.
// The master side drives the raw keys and the service acknowledges.
// The slave side is the conditioner. It returns the debounced level, the press pulse and the sticky request.
interface key_request_if #(
  parameter int NUM_KEYS = 3
);
  logic [NUM_KEYS-1:0] not_key;
  logic [NUM_KEYS-1:0] clear;
  logic [NUM_KEYS-1:0] key_pressed;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] request_pending;

  modport master (
    output not_key,
    output clear,
    input  key_pressed,
    input  press_pulse,
    input  request_pending
  );

  modport slave (
    input  not_key,
    input  clear,
    output key_pressed,
    output press_pulse,
    output request_pending
  );
endinterface

// File: rtl/key_request_conditioner.sv
// Purpose: synchronise, debounce and latch active-low push-button requests for the traffic FSM.
// Latency: a clean press first sampled at edge 1 is visible at edge 2+DEBOUNCE_CYCLES.
// Backpressure: none. Each request stays latched until the FSM acknowledges it with clear.
module key_request_conditioner #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  key_request_if.slave  kif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } key_state_e;

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [CNT_W-1:0]    cnt_q     [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d     [NUM_KEYS];
  key_state_e          state_q   [NUM_KEYS];
  key_state_e          state_d   [NUM_KEYS];
  logic [NUM_KEYS-1:0] pulse_q;
  logic [NUM_KEYS-1:0] pulse_d;
  logic [NUM_KEYS-1:0] pending_q;
  logic [NUM_KEYS-1:0] pending_d;

  // Two-flop synchroniser on the inverted (active-high) raw keys.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~kif.not_key;
      sync2_q <= sync1_q;
    end
  end

  // Per-key debounce FSM. The counter only advances while the synchronised level disagrees with the state.
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = '0;
      pulse_d[k] = 1'b0;
      case (state_q[k])
        RELEASED: begin
          if (sync2_q[k]) begin
            if (cnt_q[k] == CNT_LAST) begin
              state_d[k] = PRESSED;
              pulse_d[k] = 1'b1;
            end else begin
              cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
          end
        end
        PRESSED: begin
          if (!sync2_q[k]) begin
            if (cnt_q[k] == CNT_LAST) begin
              state_d[k] = RELEASED;
            end else begin
              cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d[k] = RELEASED;
        end
      endcase
    end
  end

  // Sticky request: a new press beats a simultaneous acknowledge so the fresh request is never lost.
  always_comb begin
    pending_d = (pending_q & ~kif.clear) | pulse_d;
  end

  // Debounce state, counter, press pulse and request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= RELEASED;
        cnt_q[k]   <= '0;
      end
      pulse_q   <= '0;
      pending_q <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
    end
  end

  // Expose the debounced level as a plain bit vector.
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      kif.key_pressed[k] = (state_q[k] == PRESSED);
    end
  end

  assign kif.press_pulse     = pulse_q;
  assign kif.request_pending = pending_q;

endmodule

// File: tb/tb_key_request_conditioner.sv
// Directed bench for key_request_conditioner, with one default instance and one DEBOUNCE_CYCLES=1 instance.
// Outputs are sampled 1 time unit after each rising edge. Inputs are changed at the same point.
// Every expected value is a hand-computed constant or a pulse count kept by the bench.
module tb_key_request_conditioner;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  key_request_if #(.NUM_KEYS(3)) kif0 ();
  key_request_if #(.NUM_KEYS(3)) kif1 ();

  key_request_conditioner #(.NUM_KEYS(3), .DEBOUNCE_CYCLES(4)) dut0 (
    .clk   (clk),
    .reset (reset),
    .kif   (kif0)
  );

  key_request_conditioner #(.NUM_KEYS(3), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .kif   (kif1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int pulse_at;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    kif0.not_key = 3'b111;
    kif0.clear   = 3'b000;
    kif1.not_key = 3'b111;
    kif1.clear   = 3'b000;
    repeat (3) tick();
    check_eq("rst_kp", kif0.key_pressed, 3'b000);
    check_eq("rst_pp", kif0.press_pulse, 3'b000);
    check_eq("rst_rp", kif0.request_pending, 3'b000);
    reset = 1'b0;
    tick();

    // Clean press on key 1: nothing through edge 5, everything rises at edge 6.
    kif0.not_key = 3'b101;
    for (int j = 1; j <= 5; j++) begin
      tick();
      check_eq("clean_early_pp", kif0.press_pulse, 3'b000);
    end
    tick();
    check_eq("clean_kp6", kif0.key_pressed, 3'b010);
    check_eq("clean_pp6", kif0.press_pulse, 3'b010);
    check_eq("clean_rp6", kif0.request_pending, 3'b010);
    tick();
    check_eq("clean_pp7", kif0.press_pulse, 3'b000);
    check_eq("clean_kp7", kif0.key_pressed, 3'b010);
    kif0.not_key = 3'b111;
    repeat (8) tick();
    check_eq("clean_rel_kp", kif0.key_pressed, 3'b000);
    check_eq("clean_rel_rp", kif0.request_pending, 3'b010);
    kif0.clear = 3'b010;
    tick();
    check_eq("clear_rp", kif0.request_pending, 3'b000);
    kif0.clear = 3'b000;
    tick();

    // Bounce on key 0: low 3, high 1, then low and held.
    pulses = 0;
    kif0.not_key = 3'b110;
    repeat (3) begin
      tick();
      if (kif0.press_pulse[0]) pulses++;
    end
    kif0.not_key = 3'b111;
    tick();
    if (kif0.press_pulse[0]) pulses++;
    kif0.not_key = 3'b110;
    for (int j = 1; j <= 5; j++) begin
      tick();
      if (kif0.press_pulse[0]) pulses++;
    end
    check_eq("bounce_glitch_pulses", pulses, 0);
    pulse_at = 0;
    for (int j = 6; j <= 15; j++) begin
      tick();
      if (kif0.press_pulse[0]) begin
        pulses++;
        if (pulse_at == 0) pulse_at = j;
      end
    end
    check_eq("bounce_pulse_at", pulse_at, 6);
    check_eq("bounce_pulses", pulses, 1);

    // Long hold on key 2 for 50 cycles, key 0 still held.
    pulses = 0;
    kif0.not_key = 3'b010;
    repeat (50) begin
      tick();
      if (kif0.press_pulse[2]) pulses++;
    end
    check_eq("hold_pulses", pulses, 1);
    check_eq("hold_kp", kif0.key_pressed, 3'b101);
    kif0.not_key = 3'b110;
    pulses = 0;
    for (int j = 1; j <= 5; j++) begin
      tick();
      if (kif0.press_pulse != 3'b000) pulses++;
    end
    check_eq("rel_kp5", kif0.key_pressed, 3'b101);
    tick();
    if (kif0.press_pulse != 3'b000) pulses++;
    check_eq("rel_kp6", kif0.key_pressed, 3'b001);
    check_eq("rel_pulses", pulses, 0);
    check_eq("rel_rp", kif0.request_pending, 3'b101);

    // A clear while key 0 is held drops the request, and holding does not re-set it.
    kif0.clear = 3'b001;
    tick();
    check_eq("held_clear_rp", kif0.request_pending, 3'b100);
    kif0.clear = 3'b000;
    repeat (10) tick();
    check_eq("held_noreset_rp", kif0.request_pending, 3'b100);
    kif0.not_key = 3'b111;
    repeat (8) tick();
    check_eq("idle_kp", kif0.key_pressed, 3'b000);

    // Clear on the same edge as a new press pulse for key 1.
    kif0.not_key = 3'b101;
    repeat (5) tick();
    kif0.clear = 3'b010;
    tick();
    check_eq("setclr_pp", kif0.press_pulse, 3'b010);
    check_eq("setclr_rp", kif0.request_pending, 3'b110);
    tick();
    check_eq("setclr_next_rp", kif0.request_pending, 3'b100);
    kif0.clear = 3'b111;
    kif0.not_key = 3'b111;
    tick();
    check_eq("clear_all_rp", kif0.request_pending, 3'b000);
    kif0.clear = 3'b000;
    repeat (8) tick();

    // Keys 0 and 2 fall together.
    kif0.not_key = 3'b010;
    repeat (5) tick();
    check_eq("sim_pp5", kif0.press_pulse, 3'b000);
    tick();
    check_eq("sim_pp6", kif0.press_pulse, 3'b101);
    check_eq("sim_rp6", kif0.request_pending, 3'b101);

    // Reset while key 1 has a debounce count of 2 and requests 101 are pending.
    kif0.not_key = 3'b000;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check_eq("midrst_kp", kif0.key_pressed, 3'b000);
    check_eq("midrst_pp", kif0.press_pulse, 3'b000);
    check_eq("midrst_rp", kif0.request_pending, 3'b000);
    reset = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      tick();
      check_eq("postrst_early_pp", kif0.press_pulse, 3'b000);
    end
    tick();
    check_eq("postrst_pp6", kif0.press_pulse, 3'b111);
    check_eq("postrst_rp6", kif0.request_pending, 3'b111);
    kif0.clear = 3'b010;
    tick();
    check_eq("clr010_rp", kif0.request_pending, 3'b101);
    kif0.clear = 3'b001;
    tick();
    check_eq("clr001_rp", kif0.request_pending, 3'b100);
    kif0.clear = 3'b000;
    tick();
    check_eq("clr_none_rp", kif0.request_pending, 3'b100);

    // DEBOUNCE_CYCLES = 1 instance: press and release latency of 3.
    kif1.not_key = 3'b101;
    repeat (2) tick();
    check_eq("d1_kp2", kif1.key_pressed, 3'b000);
    tick();
    check_eq("d1_kp3", kif1.key_pressed, 3'b010);
    check_eq("d1_pp3", kif1.press_pulse, 3'b010);
    check_eq("d1_rp3", kif1.request_pending, 3'b010);
    tick();
    check_eq("d1_pp4", kif1.press_pulse, 3'b000);
    kif1.not_key = 3'b111;
    repeat (2) tick();
    check_eq("d1_rel2", kif1.key_pressed, 3'b010);
    tick();
    check_eq("d1_rel3", kif1.key_pressed, 3'b000);
    check_eq("d1_rel_rp", kif1.request_pending, 3'b010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
